database_tx_sequencer: RTL

- Sequences a dump of the MIPS debug database to the PC over the UART transmitter.
- On a start pulse from debug_unit, it steps the database select lines through every entry. It latches each 32-bit word and sends it as 8-bit frames, one tx_start/tx_done handshake per byte.
- Sits between debug_unit (the requester), database (the resource it configures) and tx (the resource it drives).
- This replaces the ad-hoc byte shifting inside debug_unit.

---
 rtl/database_tx_sequencer_pkg.sv | 29 ++
 rtl/database_tx_sequencer_word_serializer.sv | 61 ++++++
 rtl/database_tx_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/database_tx_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// database_tx_sequencer_pkg
// Shared definitions for the debug-database dump path.
//   - state_t        : sequencer FSM encoding (3 bits)
//   - SEL_*          : database select codes, shared with database and debug_unit
//   - is_busy_state  : states during which a dump is in progress
// -----------------------------------------------------------------------------
package database_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] SEL_PC                = 3'd0;
  localparam logic [2:0] SEL_ADDER_PC          = 3'd1;
  localparam logic [2:0] SEL_INSTRUCTION_FETCH = 3'd2;
  localparam logic [2:0] SEL_CONTADOR_CICLOS   = 3'd3;

  // DONE is deliberately excluded: busy drops in the cycle DONE is entered.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_SELECT) || (s == ST_LATCH) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/database_tx_sequencer_word_serializer.sv
// -----------------------------------------------------------------------------
// database_tx_sequencer_word_serializer
// Holds one database word and walks through it least significant byte first.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_load           : capture i_word, restart at byte 0
//   i_advance        : move to the next byte (ignored on the last byte)
//   i_word           : word to capture
//   o_byte           : currently selected byte (registered)
//   o_last           : current byte is the most significant one
// -----------------------------------------------------------------------------
module database_tx_sequencer_word_serializer #(
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int OUTPUT_WORD_LENGTH   = 8
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_load,
  input  logic                            i_advance,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_word,
  output logic [OUTPUT_WORD_LENGTH-1:0]   o_byte,
  output logic                            o_last
);

  localparam int BYTES_POR_DATO = LONGITUD_INSTRUCCION / OUTPUT_WORD_LENGTH;
  localparam int BW             = (BYTES_POR_DATO > 1) ? $clog2(BYTES_POR_DATO) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_POR_DATO - 1);

  logic [LONGITUD_INSTRUCCION-1:0] r_word;
  logic [BW-1:0]                   r_byte;
  logic [OUTPUT_WORD_LENGTH-1:0]   r_byte_out;
  logic [BW-1:0]                   w_byte_next;
  logic [OUTPUT_WORD_LENGTH-1:0]   w_byte_next_val;

  // Next byte index and the byte it selects, so the output can stay a flop.
  always_comb begin
    w_byte_next     = r_byte + BW'(1);
    w_byte_next_val = OUTPUT_WORD_LENGTH'(r_word >> (w_byte_next * OUTPUT_WORD_LENGTH));
  end

  // Word register, byte counter and registered byte output.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_word     <= {LONGITUD_INSTRUCCION{1'b0}};
      r_byte     <= {BW{1'b0}};
      r_byte_out <= {OUTPUT_WORD_LENGTH{1'b0}};
    end else if (i_load) begin
      r_word     <= i_word;
      r_byte     <= {BW{1'b0}};
      r_byte_out <= i_word[OUTPUT_WORD_LENGTH-1:0];
    end else if (i_advance && !o_last) begin
      // Saturates at the last byte: never wraps back to byte 0.
      r_byte     <= w_byte_next;
      r_byte_out <= w_byte_next_val;
    end
  end

  assign o_last = (r_byte == LAST_BYTE);
  assign o_byte = r_byte_out;

endmodule

// File: rtl/database_tx_sequencer.sv
// -----------------------------------------------------------------------------
// database_tx_sequencer
// Dumps every debug-database entry to the UART transmitter, one byte per
// tx_start/tx_done handshake, least significant byte first.
// Ports:
//   i_clock, i_reset    : clock, synchronous active-high reset
//   i_start             : one-cycle dump request (honoured only in IDLE)
//   i_dato_database     : database word for the current select code
//   i_tx_done           : tx finished the last stop bit
//   o_control_database  : database select code
//   o_tx_start, o_data_tx : transmit request pulse and the byte to send
//   o_busy, o_done      : dump in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module database_tx_sequencer
  import database_tx_sequencer_pkg::*;
#(
  parameter int LONGITUD_INSTRUCCION       = 32,
  parameter int OUTPUT_WORD_LENGTH         = 8,
  parameter int CANT_BITS_CONTROL_DATABASE = 3,
  parameter int CANT_DATOS                 = 4
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic [LONGITUD_INSTRUCCION-1:0]       i_dato_database,
  input  logic                                  i_tx_done,
  output logic [CANT_BITS_CONTROL_DATABASE-1:0] o_control_database,
  output logic                                  o_tx_start,
  output logic [OUTPUT_WORD_LENGTH-1:0]         o_data_tx,
  output logic                                  o_busy,
  output logic                                  o_done
);

  localparam int CB = CANT_BITS_CONTROL_DATABASE;
  localparam logic [CB-1:0] LAST_INDEX  = CB'(CANT_DATOS - 1);
  localparam logic [CB-1:0] FIRST_INDEX = CB'(SEL_PC);

  state_t          r_state;
  state_t          w_next_state;
  logic [CB-1:0]   r_index;
  logic            r_tx_start;
  logic            r_busy;
  logic            r_done;
  logic            w_load;
  logic            w_advance;
  logic            w_index_inc;
  logic            w_index_clr;
  logic            w_last_byte;

  // Next-state and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_index_inc  = 1'b0;
    w_index_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_index_clr  = 1'b1;
          w_next_state = ST_SELECT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      // Database output lags the select by one clock.
      ST_SELECT: w_next_state = ST_LATCH;
      ST_LATCH: begin
        w_load       = 1'b1;
        w_next_state = ST_SEND;
      end
      // A tx_done coinciding with tx_start belongs to a previous frame.
      ST_SEND: w_next_state = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          if (!w_last_byte) begin
            w_advance    = 1'b1;
            w_next_state = ST_SEND;
          end else if (r_index != LAST_INDEX) begin
            w_index_inc  = 1'b1;
            w_next_state = ST_SELECT;
          end else begin
            w_next_state = ST_DONE;
          end
        end else begin
          w_next_state = ST_WAIT_TX;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, entry index and registered handshake outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_index    <= {CB{1'b0}};
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_index_clr) begin
        r_index <= FIRST_INDEX;
      end else if (w_index_inc) begin
        r_index <= r_index + CB'(1);
      end
      r_tx_start <= (w_next_state == ST_SEND);
      r_busy     <= is_busy_state(w_next_state);
      r_done     <= (w_next_state == ST_DONE);
    end
  end

  database_tx_sequencer_word_serializer #(
    .LONGITUD_INSTRUCCION (LONGITUD_INSTRUCCION),
    .OUTPUT_WORD_LENGTH   (OUTPUT_WORD_LENGTH)
  ) u_word_serializer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_word    (i_dato_database),
    .o_byte    (o_data_tx),
    .o_last    (w_last_byte)
  );

  // The index doubles as the select code, so it holds after DONE.
  assign o_control_database = r_index;
  assign o_tx_start         = r_tx_start;
  assign o_busy             = r_busy;
  assign o_done             = r_done;

endmodule
